// File: rtl/wt_dcache_rd_arb_pkg.sv
// Shared widths and payload types for the dcache read/write array arbiter.
package wt_dcache_rd_arb_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH    = 20;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;

  // Payload of the winning read, steered to the arrays and the result pipe.
  typedef struct packed {
    logic                           tag_only;
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] off;
    logic [DCACHE_TAG_WIDTH-1:0]    tag;
  } rd_payload_t;

  // Width needed to hold an index in [0, n-1], never below 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_dcache_rr_sel.sv
// Masked round-robin select: grants the lowest requesting index at or above
// ptr_i, wrapping to the lowest requesting index overall. Purely combinational.
//   req_i  : request vector
//   ptr_i  : round-robin start position
//   gnt_o  : one-hot grant (zero when no request)
module wt_dcache_rr_sel #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // First pass: requests at or above the pointer.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PtrW'(i) >= ptr_i)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    // Wrap-around pass.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Arbiter for the write-through dcache tag/data arrays. One access per cycle:
// refill blocks everything, a starved low-prio read beats high prio, then
// high-prio reads, low-prio reads, and finally the single-word write. The
// winning read is registered so the hit/data mux can steer its result back.
//   clk_i, rst_ni           : clock, async active-low reset
//   rd_prio_i/rd_req_i/...  : per-port read requests and payloads
//   rd_ack_o                : one-hot read grant (combinational)
//   wr_cl_vld_i             : refill/invalidate owns the arrays
//   wr_req_i / wr_ack_o     : word write request / grant
//   arr_*_o                 : array access of the winning read
//   sel_*_q_o               : registered owner and compare data of the result
module wt_dcache_rd_arb
  import wt_dcache_rd_arb_pkg::*;
#(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumPorts-1:0]                           rd_prio_i,
  input  logic [NumPorts-1:0]                           rd_req_i,
  input  logic [NumPorts-1:0]                           rd_tag_only_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  rd_idx_i,
  input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]  rd_off_i,
  input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]     rd_tag_i,
  output logic [NumPorts-1:0]                           rd_ack_o,
  input  logic                                          wr_cl_vld_i,
  input  logic [DCACHE_SET_ASSOC-1:0]                   wr_req_i,
  output logic                                          wr_ack_o,
  output logic                                          arr_req_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                arr_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]                arr_off_o,
  output logic                                          arr_tag_only_o,
  output logic                                          sel_vld_q_o,
  output logic [idx_width(NumPorts)-1:0]                sel_port_q_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                   sel_tag_q_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]                sel_off_q_o
);

  localparam int unsigned PORT_IDX_WIDTH = idx_width(NumPorts);
  localparam int unsigned CNT_WIDTH      = $clog2(StarveLimit + 1);

  logic [PORT_IDX_WIDTH-1:0]      ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]           starve_q, starve_d;
  logic                           sel_vld_q, sel_vld_d;
  logic [PORT_IDX_WIDTH-1:0]      sel_port_q, sel_port_d;
  logic [DCACHE_TAG_WIDTH-1:0]    sel_tag_q, sel_tag_d;
  logic [DCACHE_OFFSET_WIDTH-1:0] sel_off_q, sel_off_d;

  logic [NumPorts-1:0]       hi_req, lo_req, hi_gnt, lo_gnt;
  logic [NumPorts-1:0]       rd_ack;
  logic                      lo_pend, starved, arb_en, lo_win, wr_ack, arr_req;
  logic [PORT_IDX_WIDTH-1:0] win_idx;
  rd_payload_t               win;

  assign hi_req  = rd_req_i & rd_prio_i;
  assign lo_req  = rd_req_i & ~rd_prio_i;
  assign lo_pend = |lo_req;
  assign starved = lo_pend && (starve_q == CNT_WIDTH'(StarveLimit));
  // Reset also gates the combinational grants so nothing is acked in reset.
  assign arb_en  = rst_ni && !wr_cl_vld_i;

  wt_dcache_rr_sel #(.N(NumPorts), .PtrW(PORT_IDX_WIDTH)) i_rr_hi (
    .req_i (hi_req),
    .ptr_i (ptr_q),
    .gnt_o (hi_gnt)
  );

  wt_dcache_rr_sel #(.N(NumPorts), .PtrW(PORT_IDX_WIDTH)) i_rr_lo (
    .req_i (lo_req),
    .ptr_i (ptr_q),
    .gnt_o (lo_gnt)
  );

  // Priority resolution across groups and the word write.
  always_comb begin
    rd_ack = '0;
    lo_win = 1'b0;
    wr_ack = 1'b0;
    if (arb_en) begin
      if (starved) begin
        rd_ack = lo_gnt;
        lo_win = 1'b1;
      end else if (|hi_req) begin
        rd_ack = hi_gnt;
      end else if (lo_pend) begin
        rd_ack = lo_gnt;
        lo_win = 1'b1;
      end else begin
        wr_ack = |wr_req_i;
      end
    end
  end

  assign arr_req = |rd_ack;

  // One-hot mux of the winner's index and payload; zero when nothing granted.
  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rd_ack[i]) begin
        win_idx      = PORT_IDX_WIDTH'(i);
        win.tag_only = rd_tag_only_i[i];
        win.idx      = rd_idx_i[i];
        win.off      = rd_off_i[i];
        win.tag      = rd_tag_i[i];
      end
    end
  end

  // Next-state for pointer, starvation counter and result pipe.
  always_comb begin
    ptr_d      = ptr_q;
    starve_d   = starve_q;
    sel_vld_d  = arr_req;
    sel_port_d = sel_port_q;
    sel_tag_d  = sel_tag_q;
    sel_off_d  = sel_off_q;

    if (arr_req) begin
      ptr_d      = (win_idx == PORT_IDX_WIDTH'(NumPorts - 1)) ? '0 : win_idx + PORT_IDX_WIDTH'(1);
      sel_port_d = win_idx;
      sel_tag_d  = win.tag;
      sel_off_d  = win.off;
    end

    // Refill cycles are not counted as lost slots.
    if (!wr_cl_vld_i) begin
      if (!lo_pend || lo_win) begin
        starve_d = '0;
      end else if (starve_q != CNT_WIDTH'(StarveLimit)) begin
        starve_d = starve_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      starve_q   <= '0;
      sel_vld_q  <= 1'b0;
      sel_port_q <= '0;
      sel_tag_q  <= '0;
      sel_off_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      starve_q   <= starve_d;
      sel_vld_q  <= sel_vld_d;
      sel_port_q <= sel_port_d;
      sel_tag_q  <= sel_tag_d;
      sel_off_q  <= sel_off_d;
    end
  end

  assign rd_ack_o       = rd_ack;
  assign wr_ack_o       = wr_ack;
  assign arr_req_o      = arr_req;
  assign arr_idx_o      = win.idx;
  assign arr_off_o      = win.off;
  assign arr_tag_only_o = win.tag_only;
  assign sel_vld_q_o    = sel_vld_q;
  assign sel_port_q_o   = sel_port_q;
  assign sel_tag_q_o    = sel_tag_q;
  assign sel_off_q_o    = sel_off_q;

  a_rd_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_ack_o));
  a_rd_wr_excl:    assert property (@(posedge clk_i) disable iff (!rst_ni) !(wr_ack_o && |rd_ack_o));
  a_refill_block:  assert property (@(posedge clk_i) disable iff (!rst_ni) wr_cl_vld_i |-> !arr_req_o);

endmodule
